// File: rtl/data_mem_responder_pkg.sv
// Shared types and defaults for the data-memory responder.
// - Default widths/depth/latency used as parameter defaults by the top.
// - mem_state_t: responder FSM states.
// - wait_cnt_t:  wait-state counter (supports 0..15 wait states).
package data_mem_responder_pkg;

    localparam int unsigned DefDataW      = 16;
    localparam int unsigned DefAddrW      = 8;
    localparam int unsigned DefDepth      = 256;
    localparam int unsigned DefWaitCycles = 1;
    localparam int unsigned CntW          = 4;

    typedef logic [CntW-1:0] wait_cnt_t;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StAck  = 2'd2
    } mem_state_t;

    // Counter preload on accept: the WAIT state lasts exactly w cycles.
    function automatic wait_cnt_t wait_init(input int unsigned w);
        return (w == 0) ? '0 : wait_cnt_t'(w - 1);
    endfunction

endpackage

// File: rtl/data_mem_responder_mem_array.sv
// Single-port synchronous RAM, no reset.
// - clk_i:   clock
// - we_i:    write enable; wdata_i written to addr_i on the rising edge
// - re_i:    read enable; rdata_o loads mem[addr_i] on the rising edge and holds otherwise
// - addr_i:  word index
// - wdata_i: write data
// - rdata_o: registered read data (one-cycle read)
module data_mem_responder_mem_array #(
    parameter int unsigned DataW = 16,
    parameter int unsigned Depth = 256,
    parameter int unsigned IdxW  = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic             re_i,
    input  logic [IdxW-1:0]  addr_i,
    input  logic [DataW-1:0] wdata_i,
    output logic [DataW-1:0] rdata_o
);

    logic [DataW-1:0] mem_q [Depth];
    logic [DataW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder on the CPU data bus.
// Accepts a load/store request in IDLE, waits WaitCycles cycles, then pulses d_ack_o for one
// cycle. Stores are written and load data registered on the edge entering ACK.
// - clk_i:     processor clock
// - rst_n:     asynchronous active-low reset
// - d_req_i:   request valid, held until d_ack_o
// - d_wr_i:    1 = store, 0 = load (sampled at accept)
// - d_addr_i:  word address (sampled at accept)
// - w_data_i:  store data (sampled at accept)
// - r_data_o:  load data, valid with d_ack_o, held until the next load completes
// - d_ack_o:   one-cycle completion pulse
// - d_busy_o:  high from accept through the ack cycle
// - d_err_o:   out-of-range flag, valid with d_ack_o only
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned DataW      = DefDataW,
    parameter int unsigned AddrW      = DefAddrW,
    parameter int unsigned Depth      = DefDepth,
    parameter int unsigned WaitCycles = DefWaitCycles
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             d_req_i,
    input  logic             d_wr_i,
    input  logic [AddrW-1:0] d_addr_i,
    input  logic [DataW-1:0] w_data_i,
    output logic [DataW-1:0] r_data_o,
    output logic             d_ack_o,
    output logic             d_busy_o,
    output logic             d_err_o
);

    localparam int unsigned IdxW     = $clog2(Depth);
    localparam wait_cnt_t   WaitInit = wait_init(WaitCycles);

    mem_state_t       state_q, state_d;
    wait_cnt_t        cnt_q, cnt_d;
    logic             capture;

    logic             wr_q;
    logic [AddrW-1:0] addr_q;
    logic [DataW-1:0] wdata_q;
    logic             err_q, err_d;
    logic             rvalid_q, rvalid_d;

    logic             enter_ack;
    logic             eff_wr;
    logic [AddrW-1:0] eff_addr;
    logic [DataW-1:0] eff_wdata;
    logic             in_range;
    logic             mem_we, mem_re;
    logic [DataW-1:0] mem_rdata;

    // State register.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (d_req_i) begin
                    capture = 1'b1;
                    if (WaitCycles == 0) begin
                        state_d = StAck;
                    end else begin
                        state_d = StWait;
                        cnt_d   = WaitInit;
                    end
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d = StAck;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs.
    always_comb begin
        d_ack_o  = (state_q == StAck);
        d_busy_o = (state_q != StIdle);
        d_err_o  = err_q;
        // Reset and out-of-range loads read as zero; otherwise show the RAM read register,
        // which only updates on in-range load commits.
        r_data_o = rvalid_q ? mem_rdata : '0;
    end

    // With zero wait states the commit edge is the accept edge, so the live inputs are used
    // while still in IDLE; otherwise the captured copies.
    always_comb begin
        enter_ack = (state_d == StAck) && (state_q != StAck);
        eff_wr    = (state_q == StIdle) ? d_wr_i   : wr_q;
        eff_addr  = (state_q == StIdle) ? d_addr_i : addr_q;
        eff_wdata = (state_q == StIdle) ? w_data_i : wdata_q;
        in_range  = (32'(eff_addr) < Depth);
        mem_we    = enter_ack && eff_wr && in_range;
        mem_re    = enter_ack && !eff_wr && in_range;
        err_d     = enter_ack && !in_range;
        rvalid_d  = rvalid_q;
        if (enter_ack && !eff_wr) begin
            rvalid_d = in_range;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            if (capture) begin
                wr_q    <= d_wr_i;
                addr_q  <= d_addr_i;
                wdata_q <= w_data_i;
            end
            err_q    <= err_d;
            rvalid_q <= rvalid_d;
        end
    end

    data_mem_responder_mem_array #(
        .DataW (DataW),
        .Depth (Depth),
        .IdxW  (IdxW)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (mem_we),
        .re_i    (mem_re),
        .addr_i  (eff_addr[IdxW-1:0]),
        .wdata_i (eff_wdata),
        .rdata_o (mem_rdata)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req, wr, ack, busy, err;
    logic [7:0]  addr  [4];
    logic [15:0] wdata [4];
    logic [15:0] rdata [4];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // 0: 1 wait state, 1: 0 wait states, 2: 3 wait states, 3: 1 wait state with 128 words
    data_mem_responder #(.Depth(256), .WaitCycles(1)) u_w1 (
        .clk_i(clk), .rst_n(rst_n), .d_req_i(req[0]), .d_wr_i(wr[0]), .d_addr_i(addr[0]),
        .w_data_i(wdata[0]), .r_data_o(rdata[0]), .d_ack_o(ack[0]), .d_busy_o(busy[0]),
        .d_err_o(err[0])
    );
    data_mem_responder #(.Depth(256), .WaitCycles(0)) u_w0 (
        .clk_i(clk), .rst_n(rst_n), .d_req_i(req[1]), .d_wr_i(wr[1]), .d_addr_i(addr[1]),
        .w_data_i(wdata[1]), .r_data_o(rdata[1]), .d_ack_o(ack[1]), .d_busy_o(busy[1]),
        .d_err_o(err[1])
    );
    data_mem_responder #(.Depth(256), .WaitCycles(3)) u_w3 (
        .clk_i(clk), .rst_n(rst_n), .d_req_i(req[2]), .d_wr_i(wr[2]), .d_addr_i(addr[2]),
        .w_data_i(wdata[2]), .r_data_o(rdata[2]), .d_ack_o(ack[2]), .d_busy_o(busy[2]),
        .d_err_o(err[2])
    );
    data_mem_responder #(.Depth(128), .WaitCycles(1)) u_d128 (
        .clk_i(clk), .rst_n(rst_n), .d_req_i(req[3]), .d_wr_i(wr[3]), .d_addr_i(addr[3]),
        .w_data_i(wdata[3]), .r_data_o(rdata[3]), .d_ack_o(ack[3]), .d_busy_o(busy[3]),
        .d_err_o(err[3])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete transaction on DUT k; lat counts cycles after the accept edge up to ack.
    task automatic xact(input int k, input logic w, input logic [7:0] a, input logic [15:0] d,
                        input logic chg, output int lat, output int bcnt,
                        output logic [15:0] rd, output logic er);
        @(negedge clk);
        req[k] = 1'b1; wr[k] = w; addr[k] = a; wdata[k] = d;
        lat = -1; bcnt = 0; rd = '0; er = 1'b0;
        @(posedge clk);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (busy[k]) bcnt++;
            if (chg && c == 1) addr[k] = a ^ 8'h01;
            if (ack[k]) begin
                lat = c; rd = rdata[k]; er = err[k]; req[k] = 1'b0;
                break;
            end
        end
        req[k] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int          lat, bcnt, nack, a1, a2;
        logic [15:0] rd, rd2;
        logic        er, idle3;

        req = '0; wr = '0;
        for (int i = 0; i < 4; i++) begin
            addr[i] = '0; wdata[i] = '0;
        end
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst_ack%0d", i), 32'(ack[i]), 0);
            chk($sformatf("rst_busy%0d", i), 32'(busy[i]), 0);
            chk($sformatf("rst_rdata%0d", i), 32'(rdata[i]), 0);
            chk($sformatf("rst_err%0d", i), 32'(err[i]), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Store/load, one wait state.
        xact(0, 1'b1, 8'h12, 16'hBEEF, 1'b0, lat, bcnt, rd, er);
        chk("w1_st_lat", 32'(lat), 2);
        chk("w1_st_busy", 32'(bcnt), 2);
        chk("w1_st_err", 32'(er), 0);
        xact(0, 1'b0, 8'h12, 16'h0000, 1'b0, lat, bcnt, rd, er);
        chk("w1_ld_lat", 32'(lat), 2);
        chk("w1_ld_data", 32'(rd), 32'hBEEF);
        chk("w1_ld_err", 32'(er), 0);

        // Preload, then abort a store to the same word with reset during WAIT.
        xact(0, 1'b1, 8'h20, 16'hAAAA, 1'b0, lat, bcnt, rd, er);
        chk("pre_st_lat", 32'(lat), 2);
        @(negedge clk);
        req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 8'h20; wdata[0] = 16'h5555;
        @(posedge clk);
        @(negedge clk);
        chk("abort_wait_busy", 32'(busy[0]), 1);
        chk("abort_rdata_before", 32'(rdata[0]), 32'hBEEF);
        rst_n = 1'b0; req[0] = 1'b0;
        #1;
        chk("abort_ack", 32'(ack[0]), 0);
        chk("abort_busy", 32'(busy[0]), 0);
        chk("abort_rdata", 32'(rdata[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        nack = 0;
        repeat (6) begin
            @(negedge clk);
            if (ack[0]) nack++;
        end
        chk("abort_no_ack", 32'(nack), 0);
        xact(0, 1'b0, 8'h20, 16'h0000, 1'b0, lat, bcnt, rd, er);
        chk("abort_old_data", 32'(rd), 32'hAAAA);

        // Zero wait states.
        xact(1, 1'b1, 8'h05, 16'h0F0F, 1'b0, lat, bcnt, rd, er);
        chk("w0_st_lat", 32'(lat), 1);
        xact(1, 1'b0, 8'h05, 16'h0000, 1'b0, lat, bcnt, rd, er);
        chk("w0_ld_lat", 32'(lat), 1);
        chk("w0_ld_busy", 32'(bcnt), 1);
        chk("w0_ld_data", 32'(rd), 32'h0F0F);

        // Three wait states; address changed during WAIT must be ignored.
        xact(2, 1'b1, 8'h33, 16'h1357, 1'b0, lat, bcnt, rd, er);
        chk("w3_st_lat", 32'(lat), 4);
        xact(2, 1'b1, 8'h34, 16'h9999, 1'b0, lat, bcnt, rd, er);
        xact(2, 1'b0, 8'h33, 16'h0000, 1'b1, lat, bcnt, rd, er);
        chk("w3_ld_lat", 32'(lat), 4);
        chk("w3_ld_busy", 32'(bcnt), 4);
        chk("w3_ld_data", 32'(rd), 32'h1357);

        // 128-word instance: out-of-range accesses.
        xact(3, 1'b1, 8'h00, 16'h4321, 1'b0, lat, bcnt, rd, er);
        chk("d128_st0_err", 32'(er), 0);
        xact(3, 1'b1, 8'h80, 16'h1234, 1'b0, lat, bcnt, rd, er);
        chk("d128_oor_st_lat", 32'(lat), 2);
        chk("d128_oor_st_err", 32'(er), 1);
        xact(3, 1'b0, 8'h00, 16'h0000, 1'b0, lat, bcnt, rd, er);
        chk("d128_ld0_data", 32'(rd), 32'h4321);
        chk("d128_ld0_err", 32'(er), 0);
        xact(3, 1'b0, 8'h80, 16'h0000, 1'b0, lat, bcnt, rd, er);
        chk("d128_oor_ld_data", 32'(rd), 0);
        chk("d128_oor_ld_err", 32'(er), 1);
        chk("d128_oor_ld_lat", 32'(lat), 2);

        // Request held through ACK: store then back-to-back load of the same word.
        @(negedge clk);
        req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 8'h40; wdata[0] = 16'h7777;
        @(posedge clk);
        a1 = 0; a2 = 0; nack = 0; idle3 = 1'b1; rd2 = '0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 3) idle3 = busy[0];
            if (ack[0]) begin
                nack++;
                if (a1 == 0) begin
                    a1 = c; wr[0] = 1'b0;
                end else begin
                    a2 = c; rd2 = rdata[0]; req[0] = 1'b0;
                end
            end
        end
        req[0] = 1'b0;
        chk("hold_first_ack", 32'(a1), 2);
        chk("hold_idle_gap", 32'(idle3), 0);
        chk("hold_second_ack", 32'(a2), 5);
        chk("hold_ack_count", 32'(nack), 2);
        chk("hold_ld_data", 32'(rd2), 32'h7777);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
